// File: rtl/arb_ram_module.sv
// Shared single-port data memory with a round-robin arbiter in front of it.
// One request is granted per clock; reads return registered data one cycle
// after acceptance, tagged by a one-hot RVALID naming the requesting channel.
module arb_ram_module #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int N_CH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          REQ,
    input  logic [N_CH-1:0]          WR,
    input  logic [N_CH*ADDR_W-1:0]   ADDBUS,
    input  logic [N_CH*DATA_W-1:0]   DATAIN,
    output logic [N_CH-1:0]          GNT,
    output logic [DATA_W-1:0]        DATAOUT,
    output logic [N_CH-1:0]          RVALID
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    cand;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [N_CH-1:0]   gnt_vec;
    logic              rd_acc, wr_acc;
    logic [N_CH-1:0]   rvalid_q, rvalid_d;
    logic [DATA_W-1:0] dout_q;

    logic [ADDR_W-1:0] addr_ch [N_CH];
    logic [DATA_W-1:0] data_ch [N_CH];
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic [DATA_W-1:0] mem [DEPTH];

    // Unpack the flat per-channel buses into indexable views.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign addr_ch[gi] = ADDBUS[gi*ADDR_W +: ADDR_W];
        assign data_ch[gi] = DATAIN[gi*DATA_W +: DATA_W];
    end

    // Round-robin scan starting at the priority pointer; the wrap is an
    // explicit subtract so non-power-of-two channel counts work. No grant
    // is issued while reset is asserted.
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        if (!rst) begin
            for (int off = 0; off < N_CH; off++) begin
                cand = {1'b0, ptr_q} + (PTR_W+1)'(off);
                if (cand >= (PTR_W+1)'(N_CH)) begin
                    cand = cand - (PTR_W+1)'(N_CH);
                end
                if (!gnt_any && REQ[cand[PTR_W-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[PTR_W-1:0];
                end
            end
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign GNT      = gnt_vec;
    assign sel_addr = addr_ch[gnt_idx];
    assign sel_data = data_ch[gnt_idx];

    // Decode the accepted operation and compute next pointer / valid tag.
    always_comb begin
        ptr_d    = ptr_q;
        rvalid_d = '0;
        rd_acc   = gnt_any & ~WR[gnt_idx];
        wr_acc   = gnt_any &  WR[gnt_idx];
        if (gnt_any) begin
            ptr_d = (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
        if (rd_acc) begin
            rvalid_d = gnt_vec;
        end
    end

    // Pointer, read-valid tag and registered read data; cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            dout_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            if (rd_acc) begin
                dout_q <= mem[sel_addr];
            end
        end
    end

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[sel_addr] <= sel_data;
        end
    end

    assign DATAOUT = dout_q;
    assign RVALID  = rvalid_q;

endmodule

// File: tb/tb_arb_ram_module.sv
// Bench for arb_ram_module: directed scenarios followed by random traffic,
// checked against a queue/associative-array model of the arbiter and memory.
module tb_arb_ram_module;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  REQ, WR, GNT, RVALID;
    logic [N*AW-1:0] ADDBUS;
    logic [N*DW-1:0] DATAIN;
    logic [DW-1:0] DATAOUT;

    arb_ram_module #(.DATA_W(DW), .ADDR_W(AW), .N_CH(N)) dut (
        .clk(clk), .rst(rst), .REQ(REQ), .WR(WR), .ADDBUS(ADDBUS),
        .DATAIN(DATAIN), .GNT(GNT), .DATAOUT(DATAOUT), .RVALID(RVALID)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_ptr;
    logic [DW-1:0] m_mem [logic [AW-1:0]];
    logic [DW-1:0] m_dout;
    typedef struct { int ch; logic [DW-1:0] data; } rd_t;
    rd_t exp_q[$];

    // Per-channel requester state
    bit   [N-1:0]  r_req, r_wr;
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_data [N];

    logic [AW-1:0] pool [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                               16'h0010, 16'hFFFF, 16'h0020, 16'h0021};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner of a rotating-priority scan starting at the model pointer.
    function automatic int model_grant();
        for (int o = 0; o < N; o++) begin
            int c = (m_ptr + o) % N;
            if (r_req[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            REQ[i] = r_req[i];
            WR[i]  = r_wr[i];
            ADDBUS[i*AW +: AW] = r_addr[i];
            DATAIN[i*DW +: DW] = r_data[i];
        end
    endtask

    // One clock: apply requests, check the grant, update the model at the edge.
    task automatic step(input int exp_g, output int g);
        drive();
        #1;
        g = model_grant();
        chk("gnt_model", {28'd0, GNT}, (g < 0) ? 32'd0 : (32'd1 << g));
        if (exp_g != -2) chk("gnt_plan", {28'd0, GNT}, (exp_g < 0) ? 32'd0 : (32'd1 << exp_g));
        @(posedge clk);
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (r_wr[g]) m_mem[r_addr[g]] = r_data[g];
            else exp_q.push_back('{ch: g, data: m_mem[r_addr[g]]});
        end
        @(negedge clk);
    endtask

    task automatic set_ch(input int c, input bit req, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        r_req[c] = req; r_wr[c] = wr; r_addr[c] = a; r_data[c] = d;
    endtask

    task automatic rand_req(input int c);
        logic [AW-1:0] a;
        bit wr;
        a  = pool[$urandom_range(0, 7)];
        wr = ($urandom_range(0, 1) == 1) || !m_mem.exists(a);
        set_ch(c, ($urandom_range(0, 3) != 0), wr, a, DW'($urandom));
    endtask

    // Monitor: every cycle outside reset, compare the read-return port
    // against the oldest outstanding expected read.
    always @(negedge clk) begin : monitor
        rd_t e;
        if (!rst) begin
            if (RVALID != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_spurious", {28'd0, RVALID}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvalid", {28'd0, RVALID}, 32'd1 << e.ch);
                    chk("dataout", {16'd0, DATAOUT}, {16'd0, e.data});
                    m_dout = e.data;
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rvalid_missing", {28'd0, RVALID}, 32'd1 << e.ch);
                m_dout = e.data;
            end else begin
                chk("dataout_hold", {16'd0, DATAOUT}, {16'd0, m_dout});
            end
        end
    end

    initial begin
        int g;
        rst = 1'b1;
        m_ptr = 0;
        m_dout = '0;
        r_req = '0; r_wr = '0;
        for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_data[i] = '0; end
        drive();
        repeat (2) @(negedge clk);
        chk("rst_rvalid", {28'd0, RVALID}, 32'd0);
        chk("rst_dataout", {16'd0, DATAOUT}, 32'd0);
        r_req = '1; drive(); #1;
        chk("rst_gnt_blocked", {28'd0, GNT}, 32'd0);
        r_req = '0; drive();
        @(negedge clk);
        rst = 1'b0;
        step(-1, g);
        chk("post_rst_rvalid", {28'd0, RVALID}, 32'd0);

        // Write then read on ch0
        set_ch(0, 1, 1, 16'h0010, 16'hBEEF); step(0, g);
        set_ch(0, 1, 0, 16'h0010, 16'h0000); step(0, g);
        r_req = '0; step(-1, g);

        // Preload 0xA0..0xA3 at 0..3, one channel each, leaving the pointer at 0
        for (int i = 0; i < N; i++) begin
            r_req = '0;
            set_ch(i, 1, 1, AW'(i), DW'(16'hA0 + i));
            step(i, g);
        end
        r_req = '0;

        // Fairness: all channels read continuously
        for (int i = 0; i < N; i++) set_ch(i, 1, 0, AW'(i), '0);
        for (int i = 0; i < 5; i++) step(i % N, g);
        r_req = '0; step(-1, g);

        // Pointer wrap and skip
        set_ch(2, 1, 0, 16'h0002, '0); step(2, g);
        r_req = '0;
        set_ch(0, 1, 0, 16'h0000, '0);
        set_ch(1, 1, 0, 16'h0001, '0);
        step(0, g);
        r_req[0] = 1'b0; step(1, g);
        r_req = '0; step(-1, g);

        // Write-to-read across channels
        set_ch(1, 1, 1, 16'hFFFF, 16'h1234); step(1, g);
        r_req = '0;
        set_ch(3, 1, 0, 16'hFFFF, '0); step(3, g);
        r_req = '0; step(-1, g);

        // Reset in the cycle a ch2 read result is presented
        set_ch(2, 1, 0, 16'h0002, '0); step(2, g);
        r_req = '0; drive();
        #2 rst = 1'b1;
        #1;
        chk("midrst_rvalid", {28'd0, RVALID}, 32'd0);
        chk("midrst_dataout", {16'd0, DATAOUT}, 32'd0);
        chk("midrst_gnt", {28'd0, GNT}, 32'd0);
        m_ptr = 0; m_dout = '0; exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        set_ch(2, 1, 0, 16'h0002, '0);
        set_ch(3, 1, 0, 16'h0003, '0);
        step(2, g);
        r_req[2] = 1'b0; step(3, g);
        r_req = '0; step(-1, g);

        // Random traffic: requests held until accepted, then replaced
        for (int i = 0; i < N; i++) rand_req(i);
        for (int cyc = 0; cyc < 400; cyc++) begin
            step(-2, g);
            if (g >= 0) rand_req(g);
            for (int i = 0; i < N; i++) if (!r_req[i] && $urandom_range(0, 1) == 1) rand_req(i);
        end
        r_req = '0;
        step(-1, g);
        step(-1, g);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
